// File: rtl/start_fifo_rd_ctrl.sv
// FWFT read-side controller wrapping an external shift-register store, with one registered output slot.
// Latency: a write into an empty block is visible on if_dout/if_empty_n two cycles later.
// Backpressure: if_full_n drops when the shift register holds DEPTH entries, even if a read happens that cycle.
//
// Ports:
//   ap_clk, ap_rst_n      clock and asynchronous active-low reset
//   if_write/if_din       producer side, accepted when if_full_n is high
//   if_full_n             space available in the shift register
//   srl_we/srl_din        shift enable and data into the external shift register
//   srl_addr/srl_dout     tap select (oldest entry) and its combinational data
//   if_read               consumer pop request, effective when if_empty_n is high
//   if_empty_n/if_dout    registered head-of-queue valid flag and data
//   if_num_data_valid     occupancy (shift register + output slot), only when
//                         START_FIFO_RD_OCC_EN is defined
//
// Total capacity is DEPTH+1: DEPTH entries in the shift register plus the
// output register.
module start_fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    output logic                  srl_we,
    output logic [DATA_WIDTH-1:0] srl_din,
    output logic [ADDR_WIDTH-1:0] srl_addr,
    input  logic [DATA_WIDTH-1:0] srl_dout,
    input  logic                  if_read,
    output logic                  if_empty_n,
    output logic [DATA_WIDTH-1:0] if_dout
`ifdef START_FIFO_RD_OCC_EN
    ,
    output logic [ADDR_WIDTH:0]   if_num_data_valid
`endif
);

    localparam int              CNT_W    = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // EMPTY: output slot empty. HEAD: only the output slot holds a token.
    // BUFFERED: output slot valid and the shift register holds more.
    typedef enum logic [1:0] {
        ST_EMPTY    = 2'b00,
        ST_HEAD     = 2'b01,
        ST_BUFFERED = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] srl_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             out_vld;
    logic             srl_nonempty;
    logic             push;
    logic             pop;
    logic             load;

    assign out_vld      = (state != ST_EMPTY);
    assign srl_nonempty = (srl_cnt != '0);

    // Gated with reset so a producer sees no space while the block is held in reset.
    assign if_full_n  = (srl_cnt != CNT_FULL) & ap_rst_n;
    assign push       = if_write & if_full_n;
    assign pop        = if_read & out_vld;

    // Refill the output slot whenever it is (or is about to become) free and
    // the shift register has something to give.
    assign load       = srl_nonempty & (~out_vld | pop);

    assign srl_we     = push;
    assign srl_din    = if_din;
    assign if_empty_n = out_vld;

    // The oldest entry sits at tap srl_cnt-1. When a push and a load coincide
    // the tap is read before the shift, and after the shift the next-oldest
    // entry lands at the same tap, so order is preserved.
    assign srl_addr   = srl_nonempty ? ADDR_WIDTH'(srl_cnt - CNT_ONE) : '0;

    assign cnt_nxt    = srl_cnt + CNT_W'(push) - CNT_W'(load);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: begin
                if (load) begin
                    // A push in the same cycle keeps the shift register non-empty.
                    state_nxt = (cnt_nxt == '0) ? ST_HEAD : ST_BUFFERED;
                end
            end
            ST_HEAD: begin
                // Shift register is empty, so a pop cannot be refilled this
                // cycle; a concurrent push lands in the shift register.
                if (pop) begin
                    state_nxt = ST_EMPTY;
                end else if (push) begin
                    state_nxt = ST_BUFFERED;
                end
            end
            ST_BUFFERED: begin
                // Here every pop is paired with a load.
                if (pop && cnt_nxt == '0) begin
                    state_nxt = ST_HEAD;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state   <= ST_EMPTY;
            srl_cnt <= '0;
            if_dout <= '0;
        end else begin
            state   <= state_nxt;
            srl_cnt <= cnt_nxt;
            if (load) begin
                if_dout <= srl_dout;
            end
        end
    end

`ifdef START_FIFO_RD_OCC_EN
    logic out_vld_nxt;

    assign out_vld_nxt = load | (out_vld & ~pop);

    // Registered so it tracks srl_cnt + out_vld without a combinational adder on the output.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            if_num_data_valid <= '0;
        end else begin
            if_num_data_valid <= cnt_nxt + CNT_W'(out_vld_nxt);
        end
    end
`endif

endmodule

// File: tb/tb_start_fifo_rd_ctrl.sv
module tb_start_fifo_rd_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 1;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          ap_rst_n;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          if_full_n;
    logic          srl_we;
    logic [DW-1:0] srl_din;
    logic [AW-1:0] srl_addr;
    logic [DW-1:0] srl_dout;
    logic          if_read;
    logic          if_empty_n;
    logic [DW-1:0] if_dout;
`ifdef START_FIFO_RD_OCC_EN
    logic [AW:0]   occ;
`endif

    always #5 clk = ~clk;

    start_fifo_rd_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .ap_clk     (clk),
        .ap_rst_n   (ap_rst_n),
        .if_write   (if_write),
        .if_din     (if_din),
        .if_full_n  (if_full_n),
        .srl_we     (srl_we),
        .srl_din    (srl_din),
        .srl_addr   (srl_addr),
        .srl_dout   (srl_dout),
        .if_read    (if_read),
        .if_empty_n (if_empty_n),
        .if_dout    (if_dout)
`ifdef START_FIFO_RD_OCC_EN
        ,
        .if_num_data_valid (occ)
`endif
    );

    // External shift-register store: entry 0 is newest, taps read combinationally.
    logic [DW-1:0] sr [DEPTH];

    always @(posedge clk) begin
        if (srl_we) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                sr[i] <= sr[i-1];
            end
            sr[0] <= srl_din;
        end
    end

    assign srl_dout = sr[srl_addr];

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Compare the current head against the scoreboard; a valid head with an
    // empty scoreboard is a spurious token.
    task automatic pop_check(input string tag);
        logic [DW-1:0] e;
        if (exp_q.size() == 0) begin
            check($sformatf("%s_spurious", tag), 32'(if_empty_n), 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(if_dout), 32'(e));
        end
    endtask

    task automatic drain(input string tag, input int budget);
        if_write = 1'b0;
        if_read  = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (if_empty_n) begin
                pop_check($sformatf("%s_data", tag));
            end
            tick;
        end
        if_read = 1'b0;
        check($sformatf("%s_left", tag), 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ap_rst_n = 1'b0;
        if_write = 1'b0;
        if_read  = 1'b0;
        if_din   = '0;
        repeat (2) tick;

        // Reset: outputs forced even with a write request asserted.
        if_write = 1'b1;
        if_din   = 8'hEE;
        #1;
        check("rst_empty_n", 32'(if_empty_n), 32'd0);
        check("rst_full_n",  32'(if_full_n),  32'd0);
        check("rst_srl_we",  32'(srl_we),     32'd0);
        check("rst_dout",    32'(if_dout),    32'd0);
`ifdef START_FIFO_RD_OCC_EN
        check("rst_occ",     32'(occ),        32'd0);
`endif
        tick;
        check("rst_empty_n_edge", 32'(if_empty_n), 32'd0);
        if_write = 1'b0;
        ap_rst_n = 1'b1;
        #1;
        check("post_rst_full_n", 32'(if_full_n), 32'd1);
        tick;

        // Single write, first-word-fall-through latency of two cycles.
        if_din   = 8'hA5;
        if_write = 1'b1;
        exp_q.push_back(8'hA5);
        tick;
        if_write = 1'b0;
        check("a_lat1_empty_n", 32'(if_empty_n), 32'd0);
        tick;
        check("a_empty_n", 32'(if_empty_n), 32'd1);
        check("a_dout",    32'(if_dout),    32'hA5);
        if_read = 1'b1;
        pop_check("a_pop");
        tick;
        if_read = 1'b0;
        check("a_after_read", 32'(if_empty_n), 32'd0);
        tick;

        // Four back-to-back writes: three fit, the fourth is refused.
        for (int i = 0; i < 4; i++) begin
            if_din   = 8'(i + 1);
            if_write = 1'b1;
            if (i < 3) exp_q.push_back(8'(i + 1));
            check($sformatf("b_full_n_%0d", i), 32'(if_full_n), (i < 3) ? 32'd1 : 32'd0);
            #1;
            check($sformatf("b_srl_we_%0d", i), 32'(srl_we), (i < 3) ? 32'd1 : 32'd0);
            tick;
        end
        if_write = 1'b0;
        check("b_full_n_hold", 32'(if_full_n), 32'd0);
        drain("b", 10);

        // Streaming: one write and one read every cycle after the first fill.
        if_read = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if_din   = 8'(8'h10 + k);
            if_write = 1'b1;
            exp_q.push_back(8'(8'h10 + k));
            check($sformatf("c_full_n_%0d", k), 32'(if_full_n), 32'd1);
            if (k >= 2) begin
                check($sformatf("c_vld_%0d", k), 32'(if_empty_n), 32'd1);
            end
            if (if_empty_n) pop_check($sformatf("c_data_%0d", k));
            tick;
        end
        if_write = 1'b0;
        drain("c", 10);

        // Full with simultaneous write and read: write refused, head popped.
        for (int i = 0; i < 3; i++) begin
            if_din   = 8'(8'h20 + i);
            if_write = 1'b1;
            exp_q.push_back(8'(8'h20 + i));
            tick;
        end
        if_write = 1'b0;
        tick;
        check("d_full",    32'(if_full_n),  32'd0);
        check("d_empty_n", 32'(if_empty_n), 32'd1);
        if_din   = 8'h23;
        if_write = 1'b1;
        if_read  = 1'b1;
        #1;
        check("d_srl_we",  32'(srl_we),    32'd0);
        check("d_full_rw", 32'(if_full_n), 32'd0);
        pop_check("d_head");
        tick;
        if_write = 1'b0;
        if_read  = 1'b0;
        check("d_full_n_next", 32'(if_full_n), 32'd1);
        drain("d", 10);

        // Reset pulsed mid-cycle with two tokens queued.
        if_din   = 8'h30;
        if_write = 1'b1;
        exp_q.push_back(8'h30);
        tick;
        if_din   = 8'h31;
        exp_q.push_back(8'h31);
        tick;
        if_write = 1'b0;
        check("e_pre_empty_n", 32'(if_empty_n), 32'd1);
        check("e_pre_dout",    32'(if_dout),    32'h30);
        #3;
        ap_rst_n = 1'b0;
        #1;
        check("e_rst_empty_n", 32'(if_empty_n), 32'd0);
        check("e_rst_dout",    32'(if_dout),    32'd0);
        check("e_rst_full_n",  32'(if_full_n),  32'd0);
        exp_q.delete();
        tick;
        ap_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check($sformatf("e_no_stale_%0d", i), 32'(if_empty_n), 32'd0);
        end
        if_din   = 8'h40;
        if_write = 1'b1;
        exp_q.push_back(8'h40);
        tick;
        drain("e", 10);

`ifdef START_FIFO_RD_OCC_EN
        // Occupancy counter through fill and drain.
        for (int i = 0; i < 3; i++) begin
            if_din   = 8'(8'h50 + i);
            if_write = 1'b1;
            exp_q.push_back(8'(8'h50 + i));
            check($sformatf("occ_fill_%0d", i), 32'(occ), 32'(i));
            tick;
        end
        if_write = 1'b0;
        check("occ_full", 32'(occ), 32'd3);
        drain("occ", 10);
        check("occ_drained", 32'(occ), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/start_fifo_rd_ctrl.md
START_FIFO_RD_CTRL -- requirements
Module: start_fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1: token/data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 1: width of srl_addr, with 2**ADDR_WIDTH >= DEPTH.
REQ-003 SHALL have parameter DEPTH, default 2: number of entries in the external shift-register store.
REQ-004 SHALL have port ap_clk  in  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port ap_rst_n  in  1: reset, asynchronous and active-low.
REQ-006 SHALL have port if_write  in  1: producer write request.
REQ-007 SHALL have port if_din  in  DATA_WIDTH: producer write data.
REQ-008 SHALL have port if_full_n  out  1: high when a write is accepted this cycle.
REQ-009 SHALL have port srl_we  out  1: shift enable to the external shift register.
REQ-010 SHALL have port srl_din  out  DATA_WIDTH: data into the external shift register.
REQ-011 SHALL have port srl_addr  out  ADDR_WIDTH: read tap select into the external shift register.
REQ-012 SHALL have port srl_dout  in  DATA_WIDTH: combinational tap data from the external shift register.
REQ-013 SHALL have port if_read  in  1: consumer read request.
REQ-014 SHALL have port if_empty_n  out  1: high when if_dout holds a valid token.
REQ-015 SHALL have port if_dout  out  DATA_WIDTH: registered head-of-queue data.

Function
REQ-016 SHALL keep srl_cnt (0..DEPTH), the shift-register occupancy, and out_vld, the output-register valid flag; total capacity is DEPTH+1.
REQ-017 SHALL drive if_full_n = (srl_cnt != DEPTH) and ap_rst_n.
REQ-018 SHALL define push = if_write and if_full_n, drive srl_we = push and srl_din = if_din; a write with if_full_n low is ignored.
REQ-019 SHALL drive if_empty_n = out_vld and define pop = if_read and out_vld; a read while empty has no effect.
REQ-020 SHALL drive srl_addr = srl_cnt-1 (oldest entry) when srl_cnt > 0, else 0.
REQ-021 SHALL load when srl_cnt > 0 and (out_vld = 0 or pop): if_dout <= srl_dout, out_vld <= 1.
REQ-022 SHALL clear out_vld on pop without load; if_dout holds its value when not loaded.
REQ-023 SHALL update srl_cnt <= srl_cnt + push - load; simultaneous push and load leaves srl_cnt unchanged and preserves FIFO order.
REQ-024 SHALL present first-word-fall-through: a push into a fully empty block raises if_empty_n exactly 2 cycles later with if_dout = that data.
REQ-025 SHALL sustain one push and one pop per cycle when neither full nor empty.
REQ-026 SHALL expose states EMPTY (out_vld=0), HEAD (out_vld=1, srl_cnt=0), BUFFERED (out_vld=1, srl_cnt>0); EMPTY->HEAD via load, HEAD->BUFFERED via push without pop, BUFFERED->HEAD when last entry is loaded with no push, HEAD->EMPTY on pop with srl_cnt=0 and no push.
REQ-027 SHALL never emit a token twice or drop an accepted token, including when srl_cnt = DEPTH and pop occurs alongside if_write (write refused that cycle since if_full_n is low).

Reset
REQ-028 SHALL, while ap_rst_n is low, asynchronously force srl_cnt=0, out_vld=0, if_dout=0, if_empty_n=0, if_full_n=0, srl_we=0.
REQ-029 SHALL discard all queued tokens on reset mid-operation; the external shift register contents are don't-care afterwards.
REQ-030 SHALL raise if_full_n in the first cycle after ap_rst_n deasserts.

Configuration
REQ-031 SHALL, with START_FIFO_RD_OCC_EN defined, add output if_num_data_valid (ADDR_WIDTH+1 bits) = srl_cnt + out_vld, reset to 0.
REQ-032 SHALL, without START_FIFO_RD_OCC_EN, omit that port, with all other behaviour identical.

Verification (DEPTH=2, DATA_WIDTH=8)
REQ-033 SHALL cover reset then single write 0xA5 at cycle T -> if_empty_n=1, if_dout=0xA5 at T+2; read -> if_empty_n=0 next cycle.
REQ-034 SHALL cover writes 0x01,0x02,0x03,0x04 back-to-back, no reads -> first three accepted, if_full_n=0 from T+3, 0x04 refused; reads return 0x01,0x02,0x03.
REQ-035 SHALL cover continuous write and read of 0x10..0x1F after first fill -> one token per cycle, in order, srl_cnt constant.
REQ-036 SHALL cover full (3 tokens) with if_write and if_read together -> write refused, head popped, if_full_n=1 next cycle.
REQ-037 SHALL cover ap_rst_n pulsed low mid-cycle with 2 tokens queued -> if_empty_n=0 and if_dout=0 immediately, no stale token after release.
REQ-038 SHALL cover START_FIFO_RD_OCC_EN defined -> if_num_data_valid counts 0,1,2,3 during fill and returns to 0 after drain.
